// File: rtl/add_arbiter.sv
// ---------------------------------------------------------------------------
// add_arbiter
//
// Purpose:
//   Shares one registered adder (1-cycle latency) between N_REQ requesters
//   using round-robin arbitration. One transaction is in flight at a time:
//   the winner's operands are latched and driven to the adder, the sum is
//   captured one cycle later and returned with the requester id over a
//   valid/ready response channel.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   req         per-requester request, held until the matching gnt bit
//   req_a       packed operand a, slice i belongs to requester i
//   req_b       packed operand b, slice i belongs to requester i
//   gnt         one-hot 1-cycle pulse: that requester's operands were taken
//   add_a       operand a to the shared adder
//   add_b       operand b to the shared adder
//   add_result  adder output, valid 1 cycle after the operands are presented
//   rsp_valid   response valid
//   rsp_ready   response accept
//   rsp_id      index of the requester owning the response
//   rsp_data    sum returned by the adder
//   busy        high in every state except IDLE
// ---------------------------------------------------------------------------
module add_arbiter #(
  parameter int N_REQ        = 4,
  parameter int WIDTH_A      = 32,
  parameter int WIDTH_B      = 4,
  parameter int RESULT_WIDTH = 33,
  parameter int ID_W         = ($clog2(N_REQ) > 0 ? $clog2(N_REQ) : 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WIDTH_A-1:0]  req_a,
  input  logic [N_REQ*WIDTH_B-1:0]  req_b,
  output logic [N_REQ-1:0]          gnt,
  output logic [WIDTH_A-1:0]        add_a,
  output logic [WIDTH_B-1:0]        add_b,
  input  logic [RESULT_WIDTH-1:0]   add_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [RESULT_WIDTH-1:0]   rsp_data,
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [ID_W-1:0]           r_last_grant;
  logic [N_REQ-1:0]          r_gnt;
  logic [WIDTH_A-1:0]        r_add_a;
  logic [WIDTH_B-1:0]        r_add_b;
  logic                      r_rsp_valid;
  logic [ID_W-1:0]           r_rsp_id;
  logic [RESULT_WIDTH-1:0]   r_rsp_data;

  logic                      w_found;
  logic [ID_W-1:0]           w_win;
  logic [N_REQ-1:0]          w_win_onehot;
  logic [WIDTH_A-1:0]        w_sel_a;
  logic [WIDTH_B-1:0]        w_sel_b;
  logic                      w_arb_load;
  logic                      w_capture;
  logic                      w_rsp_done;

  // Round-robin search: start one past the last winner and wrap, so the
  // most recently served requester has the lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_found && req[(int'(r_last_grant) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = ID_W'((int'(r_last_grant) + k) % N_REQ);
      end
    end
  end

  assign w_win_onehot = N_REQ'(1) << w_win;
  assign w_sel_a      = req_a[w_win*WIDTH_A +: WIDTH_A];
  assign w_sel_b      = req_b[w_win*WIDTH_B +: WIDTH_B];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    w_arb_load  = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_arb_load  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      // The adder samples add_a/add_b at the end of this cycle.
      S_ISSUE: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      // Arbitration resumes only in the following IDLE cycle.
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Grant, operand and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= ID_W'(N_REQ - 1);
      r_gnt        <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_data   <= '0;
    end else begin
      // gnt is a single-cycle pulse, visible only during ISSUE.
      r_gnt <= '0;
      if (w_arb_load) begin
        r_gnt        <= w_win_onehot;
        r_add_a      <= w_sel_a;
        r_add_b      <= w_sel_b;
        r_rsp_id     <= w_win;
        r_last_grant <= w_win;
      end
      if (w_capture) begin
        r_rsp_data  <= add_result;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign gnt       = r_gnt;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_add_arbiter
//
// Directed bench for add_arbiter (N_REQ=4). Includes a behavioural model of
// the shared 1-cycle registered adder. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_add_arbiter;

  localparam int N_REQ        = 4;
  localparam int WIDTH_A      = 32;
  localparam int WIDTH_B      = 4;
  localparam int RESULT_WIDTH = 33;
  localparam int ID_W         = 2;

  logic                      clk;
  logic                      reset;
  logic [N_REQ-1:0]          req;
  logic [N_REQ*WIDTH_A-1:0]  req_a;
  logic [N_REQ*WIDTH_B-1:0]  req_b;
  logic [N_REQ-1:0]          gnt;
  logic [WIDTH_A-1:0]        add_a;
  logic [WIDTH_B-1:0]        add_b;
  logic [RESULT_WIDTH-1:0]   add_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [RESULT_WIDTH-1:0]   rsp_data;
  logic                      busy;

  int n_checks = 0;
  int n_errors = 0;

  add_arbiter #(
    .N_REQ        (N_REQ),
    .WIDTH_A      (WIDTH_A),
    .WIDTH_B      (WIDTH_B),
    .RESULT_WIDTH (RESULT_WIDTH),
    .ID_W         (ID_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared adder model: registered sum, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) add_result <= '0;
    else       add_result <= RESULT_WIDTH'(add_a) + RESULT_WIDTH'(add_b);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and check the always-true invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    chk("gnt_and_valid", 64'((gnt != '0) && rsp_valid), 64'd0);
  endtask

  task automatic set_op(input int i, input logic [WIDTH_A-1:0] a, input logic [WIDTH_B-1:0] b);
    req_a[i*WIDTH_A +: WIDTH_A] = a;
    req_b[i*WIDTH_B +: WIDTH_B] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One full transaction with rsp_ready high, starting in an IDLE cycle
  // where req is already presented. req is dropped after the grant when
  // drop is set.
  task automatic txn(input string tag, input logic [N_REQ-1:0] exp_gnt,
                     input logic [ID_W-1:0] exp_id,
                     input logic [RESULT_WIDTH-1:0] exp_data, input bit drop);
    tick();
    chk({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    if (drop) req = '0;
    tick();
    chk({tag, "_capture_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_capture_valid"}, 64'(rsp_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_id"}, 64'(rsp_id), 64'(exp_id));
    chk({tag, "_data"}, 64'(rsp_data), 64'(exp_data));
    tick();
    chk({tag, "_done_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_done_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ID_W-1:0]         hold_id;
    logic [RESULT_WIDTH-1:0] hold_data;

    reset     = 1'b1;
    req       = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;
    do_reset();

    // Reset state
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    chk("rst_add_b", 64'(add_b), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);

    // 1. Single request: 5 + 3
    req = 4'b0001;
    set_op(0, 32'd5, 4'd3);
    tick();
    chk("t1_gnt", 64'(gnt), 64'h1);
    chk("t1_add_a", 64'(add_a), 64'd5);
    chk("t1_add_b", 64'(add_b), 64'd3);
    req = '0;
    tick();
    chk("t1_c2_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_data", 64'(rsp_data), 64'd8);
    tick();
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_valid_low", 64'(rsp_valid), 64'd0);

    // 2. All requesting after a fresh reset: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_op(i, WIDTH_A'(100 + i), WIDTH_B'(i));
    req = 4'b1111;
    txn("t2_r0", 4'b0001, 2'd0, 33'd100, 1'b0);
    txn("t2_r1", 4'b0010, 2'd1, 33'd102, 1'b0);
    txn("t2_r2", 4'b0100, 2'd2, 33'd104, 1'b0);
    txn("t2_r3", 4'b1000, 2'd3, 33'd106, 1'b0);
    txn("t2_r0b", 4'b0001, 2'd0, 33'd100, 1'b1);

    // 3. Backpressure (last_grant = 0)
    set_op(2, 32'h1234, 4'd5);
    set_op(0, 32'd5, 4'd3);
    req       = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    chk("t3_gnt", 64'(gnt), 64'h4);
    req = '0;
    tick();
    tick();
    chk("t3_valid", 64'(rsp_valid), 64'd1);
    chk("t3_id", 64'(rsp_id), 64'd2);
    chk("t3_data", 64'(rsp_data), 64'h1239);
    hold_id   = rsp_id;
    hold_data = rsp_data;
    req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t3_hold_id", 64'(rsp_id), 64'(hold_id));
      chk("t3_hold_data", 64'(rsp_data), 64'(hold_data));
      chk("t3_hold_gnt", 64'(gnt), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("t3_hs_valid", 64'(rsp_valid), 64'd0);
    chk("t3_hs_gnt", 64'(gnt), 64'd0);
    chk("t3_hs_busy", 64'(busy), 64'd0);
    tick();
    chk("t3_next_gnt", 64'(gnt), 64'h1);
    req = '0;
    tick();
    tick();
    chk("t3_next_data", 64'(rsp_data), 64'd8);
    tick();

    // 4. Wrap and overflow: move last_grant to 3, then req=1001
    set_op(3, 32'd1, 4'd1);
    req = 4'b1000;
    txn("t4_pre", 4'b1000, 2'd3, 33'd2, 1'b1);
    set_op(0, 32'hFFFF_FFFF, 4'hF);
    set_op(3, 32'd7, 4'd2);
    req = 4'b1001;
    txn("t4_wrap", 4'b0001, 2'd0, 33'h1_0000_000E, 1'b0);
    txn("t4_next", 4'b1000, 2'd3, 33'd9, 1'b1);

    // 5. Reset asserted during CAPTURE
    set_op(2, 32'd50, 4'd1);
    req = 4'b0100;
    tick();
    chk("t5_gnt", 64'(gnt), 64'h4);
    req = '0;
    tick();
    reset = 1'b1;
    tick();
    chk("t5_rst_valid", 64'(rsp_valid), 64'd0);
    chk("t5_rst_gnt", 64'(gnt), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_add_a", 64'(add_a), 64'd0);
    chk("t5_rst_data", 64'(rsp_data), 64'd0);
    reset = 1'b0;
    set_op(1, 32'd20, 4'd2);
    req = 4'b0010;
    txn("t5_after", 4'b0010, 2'd1, 33'd22, 1'b1);

    // 6. Request raised during RESP of another transaction
    set_op(0, 32'd10, 4'd1);
    set_op(2, 32'd30, 4'd4);
    req = 4'b0001;
    tick();
    chk("t6_first_gnt", 64'(gnt), 64'h1);
    req = '0;
    tick();
    tick();
    chk("t6_first_valid", 64'(rsp_valid), 64'd1);
    chk("t6_first_data", 64'(rsp_data), 64'd11);
    req = 4'b0100;
    tick();
    chk("t6_idle_gnt", 64'(gnt), 64'd0);
    chk("t6_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("t6_late_gnt", 64'(gnt), 64'h4);
    req = '0;
    tick();
    tick();
    chk("t6_late_id", 64'(rsp_id), 64'd2);
    chk("t6_late_data", 64'(rsp_data), 64'd34);
    tick();
    chk("t6_end_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
